// File: rtl/bcd_accumulator.sv
// Handshake consumer that sums N two-digit BCD samples into a three-digit BCD
// total, publishing each completed batch on registered outputs with a done flag.
module bcd_accumulator #(
    parameter int unsigned N = 4
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       dav_,
    output logic       rfd,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic [3:0] s2,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       done,
    output logic       err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } bcd3_t;

    // Single BCD digit add: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                 input logic cin);
        logic [4:0] raw;
        logic [4:0] adj;
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        adj = raw - 5'd10;
        if (raw > 5'd9) return {1'b1, adj[3:0]};
        else            return {1'b0, raw[3:0]};
    endfunction

    state_t        state_q, state_d;
    bcd3_t         acc_q, acc_d;
    bcd3_t         res_q, res_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          capture;
    logic          valid;
    logic          last;
    logic [4:0]    add_u, add_t, add_h;
    bcd3_t         sum;

    assign capture = (state_q == S_WAIT) && !dav_;
    assign valid   = (d1 <= 4'd9) && (d0 <= 4'd9);
    assign last    = (count_q == CW'(N - 1));

    always_comb begin
        add_u = bcd_digit_add(acc_q.u, d0, 1'b0);
        add_t = bcd_digit_add(acc_q.t, d1, add_u[4]);
        // Hundreds digit drops its carry, so it wraps mod 10 past 999.
        add_h = bcd_digit_add(acc_q.h, 4'd0, add_t[4]);
        sum   = '{h: add_h[3:0], t: add_t[3:0], u: add_u[3:0]};
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_WAIT: begin
                if (capture) begin
                    state_d = S_ACK;
                    if (!valid) begin
                        err_d = 1'b1;
                    end else if (last) begin
                        res_d   = sum;
                        done_d  = 1'b1;
                        acc_d   = '0;
                        count_d = '0;
                    end else begin
                        acc_d   = sum;
                        count_d = count_q + 1'b1;
                        // First valid sample of a new batch retires the previous result flag.
                        if (count_q == '0) done_d = 1'b0;
                    end
                end
            end
            S_ACK: begin
                if (dav_) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_WAIT;
            acc_q   <= '0;
            res_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rfd  = (state_q == S_WAIT);
    assign s2   = res_q.h;
    assign s1   = res_q.t;
    assign s0   = res_q.u;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_accumulator.sv
// Drives one shared handshake stream into four accumulators (N=1..4) and checks
// each against an integer-arithmetic model every cycle, plus literal batch results.
module tb_bcd_accumulator;

    logic       clock;
    logic       reset_;
    logic       dav_;
    logic [3:0] d1, d0;

    logic       rfd_w  [4];
    logic       done_w [4];
    logic       err_w  [4];
    logic [3:0] s2_w   [4];
    logic [3:0] s1_w   [4];
    logic [3:0] s0_w   [4];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bcd_accumulator #(.N(g + 1)) u_dut (
            .clock (clock),
            .reset_(reset_),
            .dav_  (dav_),
            .rfd   (rfd_w[g]),
            .d1    (d1),
            .d0    (d0),
            .s2    (s2_w[g]),
            .s1    (s1_w[g]),
            .s0    (s0_w[g]),
            .done  (done_w[g]),
            .err   (err_w[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: plain integer sums, converted to decimal digits on compare.
    bit m_wait          = 1'b1;
    int m_acc    [4]    = '{default: 0};
    int m_count  [4]    = '{default: 0};
    int m_result [4]    = '{default: 0};
    bit m_done   [4]    = '{default: 1'b0};
    bit m_err           = 1'b0;
    bit model_on        = 1'b0;

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            m_wait = 1'b1;
            m_err  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0; m_count[k] = 0; m_result[k] = 0; m_done[k] = 1'b0;
            end
        end else if (m_wait && !dav_) begin
            m_wait = 1'b0;
            if (d1 > 9 || d0 > 9) begin
                m_err = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    m_acc[k] += 10 * int'(d1) + int'(d0);
                    m_count[k]++;
                    if (m_count[k] == k + 1) begin
                        m_result[k] = m_acc[k] % 1000;
                        m_acc[k] = 0; m_count[k] = 0; m_done[k] = 1'b1;
                    end else if (m_count[k] == 1) begin
                        m_done[k] = 1'b0;
                    end
                end
            end
        end else if (!m_wait && dav_) begin
            m_wait = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rfd[N=%0d]", k + 1),  int'(rfd_w[k]),  int'(m_wait));
                check($sformatf("done[N=%0d]", k + 1), int'(done_w[k]), int'(m_done[k]));
                check($sformatf("err[N=%0d]", k + 1),  int'(err_w[k]),  int'(m_err));
                check($sformatf("s2[N=%0d]", k + 1),   int'(s2_w[k]),   m_result[k] / 100);
                check($sformatf("s1[N=%0d]", k + 1),   int'(s1_w[k]),   (m_result[k] / 10) % 10);
                check($sformatf("s0[N=%0d]", k + 1),   int'(s0_w[k]),   m_result[k] % 10);
            end
        end
    end

    function automatic int result_of(input int k);
        return 100 * int'(s2_w[k]) + 10 * int'(s1_w[k]) + int'(s0_w[k]);
    endfunction

    task automatic do_reset();
        @(posedge clock); #1;
        dav_ = 1'b1; reset_ = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_ = 1'b1;
    endtask

    task automatic wait_rfd(input logic level, input string name);
        int n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (rfd_w[0] !== level && n < 10);
        check(name, int'(rfd_w[0]), int'(level));
    endtask

    // One full handshake holding dav_ low for 'hold' cycles after the capture edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input int hold);
        d1 = a; d0 = b; dav_ = 1'b0;
        wait_rfd(1'b0, "rfd_fall_timeout");
        repeat (hold - 1) begin
            @(posedge clock); #1;
        end
        dav_ = 1'b1;
        wait_rfd(1'b1, "rfd_rise_timeout");
        @(posedge clock); #1;
    endtask

    initial begin
        reset_ = 1'b1; dav_ = 1'b1; d1 = 4'd0; d0 = 4'd0;
        #1 reset_ = 1'b0;
        model_on = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_ = 1'b1;

        // Idle after reset
        repeat (10) @(posedge clock);
        #1;
        check("idle_rfd", int'(rfd_w[3]), 1);
        check("idle_done", int'(done_w[3]), 0);
        check("idle_result", result_of(3), 0);

        // N=4: 99 x4 -> 396
        do_reset();
        for (int i = 0; i < 3; i++) send(4'd9, 4'd9, 1);
        check("n4_pre_done", int'(done_w[3]), 0);
        check("n4_pre_result", result_of(3), 0);
        send(4'd9, 4'd9, 1);
        check("n4_396", result_of(3), 396);
        check("n4_done", int'(done_w[3]), 1);

        // N=3: 45+27+08 -> 080, then 11 clears done but keeps result
        do_reset();
        send(4'd4, 4'd5, 1);
        send(4'd2, 4'd7, 2);
        send(4'd0, 4'd8, 1);
        check("n3_080", result_of(2), 80);
        check("n3_done", int'(done_w[2]), 1);
        send(4'd1, 4'd1, 1);
        check("n3_done_cleared", int'(done_w[2]), 0);
        check("n3_result_held", result_of(2), 80);
        check("n1_tracks_last", result_of(0), 11);
        check("n1_done_stays", int'(done_w[0]), 1);

        // Long dav_ low: a single capture; a second 12 completes N=2 as 024
        do_reset();
        send(4'd1, 4'd2, 6);
        check("hold_n2_done", int'(done_w[1]), 0);
        check("hold_n1_result", result_of(0), 12);
        send(4'd1, 4'd2, 1);
        check("hold_n2_024", result_of(1), 24);

        // Illegal 3A is dropped, err sticks, 50+25 -> 075
        do_reset();
        send(4'd3, 4'hA, 1);
        check("bad_err", int'(err_w[1]), 1);
        check("bad_n1_not_done", int'(done_w[0]), 0);
        send(4'd5, 4'd0, 1);
        send(4'd2, 4'd5, 1);
        check("bad_n2_075", result_of(1), 75);
        check("bad_n2_done", int'(done_w[1]), 1);
        check("bad_err_sticky", int'(err_w[1]), 1);

        // Reset while in S_ACK loses partial batch; then 10 x4 -> 040
        do_reset();
        send(4'd1, 4'd0, 1);
        d1 = 4'd2; d0 = 4'd0; dav_ = 1'b0;
        wait_rfd(1'b0, "mid_rfd_fall_timeout");
        reset_ = 1'b0;
        #1 check("mid_rst_rfd", int'(rfd_w[3]), 1);
        dav_ = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_ = 1'b1;
        for (int i = 0; i < 4; i++) send(4'd1, 4'd0, 1);
        check("mid_n4_040", result_of(3), 40);
        check("mid_n4_done", int'(done_w[3]), 1);
        check("mid_err_clear", int'(err_w[3]), 0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        model_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
